// File: rtl/mc_rr_sched.sv
// Round-robin scheduler sharing one multi-cycle resource among N requesters.
// A winner is granted, the resource gets a one-cycle START, the grant is held
// for LATENCY cycles, the winner receives a one-cycle ACK, and then GAP idle
// cycles let the repeater lines settle before arbitration resumes.
module mc_rr_sched #(
    parameter int N       = 4,
    parameter int LATENCY = 3,
    parameter int GAP     = 1,
    parameter int SELW    = $clog2(N)
) (
    input  logic            CLK,
    input  logic            ARST_N,
    input  logic [N-1:0]    REQ,
    output logic [N-1:0]    GNT,
    output logic [SELW-1:0] SEL,
    output logic            START,
    output logic [N-1:0]    ACK,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    // Counter reload values; the GAP reload is only used when GAP > 0.
    localparam logic [3:0]    LAT_M1 = 4'(LATENCY - 1);
    localparam logic [3:0]    GAP_M1 = 4'((GAP > 0) ? (GAP - 1) : 0);
    // One extra bit so ptr + offset never overflows before the wrap test.
    localparam logic [SELW:0] N_W    = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);
    localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            start_q, start_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [SELW-1:0] win;
    logic [SELW:0]   idx;

    // Rotating priority search: first set REQ bit at or above ptr, wrapping at N-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (SELW + 1)'(i);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!found && REQ[idx[SELW-1:0]]) begin
                found = 1'b1;
                win   = idx[SELW-1:0];
            end
        end
    end

    // Next-state and next-output logic for the IDLE / BUSY / SETTLE sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        ack_d   = '0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = ONE << win;
                    sel_d   = win;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    gnt_d = '0;
                    ack_d = ONE << sel_q;
                    // Winner drops to lowest priority for the next round.
                    ptr_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
                    if (GAP > 0) begin
                        state_d = S_SETTLE;
                        cnt_d   = GAP_M1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation without an ACK.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign START = start_q;
    assign ACK   = ack_q;
    assign BUSY  = busy_q;

endmodule

// File: doc/mc_rr_sched.md
Name: mc_rr_sched

Overview:
- Round-robin scheduler that shares one multi-tick redstone resource among N requesters, such as a shared wide reduction tree or a register-file port built from the MC_* cells.
- Grants one requester at a time and issues a start pulse to the resource.
- Holds the grant for a fixed LATENCY, then acks the winner.
- Inserts GAP idle cycles after each operation so repeater lines can settle before the next operation.

Parameters:
N, 4, number of requesters; legal range 2..16, need not be a power of two.
LATENCY, 3, resource latency in CLK cycles from START to result valid; legal range 1..15.
GAP, 1, settle cycles after each ACK before arbitration resumes; legal range 0..15.
SELW, $clog2(N), width of SEL; derived, do not override.

Ports:
CLK  input  1  clock, positive-edge
ARST_N  input  1  reset, asynchronous, active-low; one clock domain only
REQ  input  N  per-requester request level, sampled only in IDLE
GNT  output  N  one-hot grant, held for the whole operation
SEL  output  SELW  binary index of the granted requester, drives the resource input mux
START  output  1  one-cycle pulse to the resource on the first grant cycle
ACK  output  N  one-hot, one-cycle pulse to the winner when the result is valid
BUSY  output  1  high in the BUSY and SETTLE states

Behaviour:
- All outputs are registered.
- Reset (ARST_N low) takes effect immediately, with no clock needed:
  - state=IDLE, PTR=0, CNT=0;
  - GNT=0, SEL=0, START=0, ACK=0, BUSY=0.
- Reset mid-operation aborts the operation: no ACK is issued and the resource is simply abandoned.
- States are IDLE, BUSY and SETTLE.
- IDLE:
  - At a CLK edge with REQ!=0, the winner is the first set REQ bit scanning upward from PTR and wrapping N-1 -> 0.
  - At that edge: GNT=onehot(winner), SEL=winner, START=1, BUSY=1, CNT=LATENCY-1, state=BUSY.
  - With REQ=0 the block stays in IDLE and all outputs stay 0.
- BUSY:
  - START returns to 0 after one cycle. GNT and SEL hold.
  - CNT decrements every edge.
  - At the edge where CNT==0:
    - GNT=0 and ACK=onehot(SEL);
    - PTR=(SEL+1) mod N, so the winner gets lowest priority next;
    - if GAP>0: state=SETTLE, CNT=GAP-1, BUSY stays 1;
    - if GAP==0: state=IDLE, BUSY=0.
  - SEL keeps its last value after the operation; it is cleared only by reset.
- SETTLE:
  - ACK clears after one cycle. CNT decrements every edge.
  - At the edge where CNT==0: state=IDLE, BUSY=0.
- Timing:
  - With the grant edge as E0, ACK rises at edge E(LATENCY).
  - The minimum spacing between START pulses is LATENCY+GAP+1 cycles.
- REQ changes outside IDLE are ignored.
  - Dropping REQ mid-operation does not abort; the operation completes and ACK is still issued.
  - A requester that holds REQ high after its ACK is re-arbitrated normally under the rotated PTR.
- Fairness: with all N requesting continuously, grants rotate strictly p, p+1, ... mod N. No requester waits more than N-1 operations.
- Invariants:
  - GNT and ACK are each one-hot or zero, and are never nonzero in the same cycle.
  - START implies GNT!=0.
- CNT width is 4 bits.
  - Non-power-of-two N: the pointer increment wraps explicitly at N-1.
  - SEL values of N or more are never produced.

Test Plan:
- Single request, N=4, LATENCY=3, GAP=1. REQ=0100 is held through edge 0.
  - Edge 1: GNT=0100, SEL=2, START=1, BUSY=1.
  - Edges 2-3: GNT held, START=0.
  - Edge 4: GNT=0, ACK=0100, BUSY=1.
  - Edge 5: BUSY=0, ACK=0.
- All requesting, same config. REQ=1111 is held.
  - GNT sequence: 0001, 0010, 0100, 1000, 0001.
  - START pulses are exactly 5 cycles apart.
- Rotation skip. PTR=2 after a prior grant to 1, and REQ=0011.
  - Next grant is requester 0, with GNT=0001 and SEL=0.
  - PTR then becomes 1.
- GAP=0, LATENCY=1. REQ=0001 is held.
  - START fires every 2 cycles.
  - ACK for each operation coincides with the IDLE cycle that precedes the next START.
- Reset mid-operation. ARST_N is pulled low one cycle after START, between clock edges.
  - All outputs go to 0 immediately and no ACK ever fires.
  - After release with REQ=0010: GNT=0010, since PTR was reset to 0.
- N=3, LATENCY=2, GAP=2. REQ=111 is held.
  - Grant order 0, 1, 2, 0, confirming wrap at 2 -> 0.
  - SEL never reaches 3.
  - BUSY is low for exactly 1 cycle between operations.
